// File: rtl/rgb_led_pkg.sv
// Shared encodings for the RGB LED driver controller: command modes and FSM states.
package rgb_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_WARM,
        ST_RUN,
        ST_SHUTDOWN
    } state_e;

    localparam int NUM_CH = 3;  // channel index 0 red, 1 green, 2 blue

endpackage

// File: rtl/rgb_pwm_core.sv
// Free-running PWM frame counter, per-channel duty compares and blink phase tracking.
module rgb_pwm_core import rgb_led_pkg::*; #(
    parameter int PWM_BITS   = 8,
    parameter int BLINK_BITS = 8
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             run,
    input  logic                             restart,
    input  logic                             blink_en,
    input  logic [BLINK_BITS-1:0]            period,
    input  logic [NUM_CH-1:0][PWM_BITS-1:0]  duty,
    output logic                             frame_end,
    output logic [NUM_CH-1:0]                pwm
);

    logic [PWM_BITS-1:0]   pwm_ctr;
    logic [BLINK_BITS-1:0] frame_ctr;
    logic [BLINK_BITS-1:0] last_frame;
    logic                  phase;
    logic [NUM_CH-1:0]     cmp;

    assign frame_end  = run & (pwm_ctr == '1);
    assign last_frame = (period == '0) ? '0 : period - BLINK_BITS'(1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign cmp[c] = phase & (pwm_ctr < duty[c]);
    end

    // Counters sit at zero with phase ON whenever not running, so entering RUN
    // always starts a clean frame.
    always_ff @(posedge clk) begin
        if (!rstn || !run) begin
            pwm_ctr   <= '0;
            frame_ctr <= '0;
            phase     <= 1'b1;
            pwm       <= '0;
        end else begin
            pwm_ctr <= pwm_ctr + PWM_BITS'(1);
            pwm     <= cmp;
            if (frame_end) begin
                if (restart || !blink_en) begin
                    phase     <= 1'b1;
                    frame_ctr <= '0;
                end else if (frame_ctr == last_frame) begin
                    phase     <= ~phase;
                    frame_ctr <= '0;
                end else begin
                    frame_ctr <= frame_ctr + BLINK_BITS'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rgb_led_ctrl.sv
// Power sequencing, single-slot command buffer and PWM control for the SB_RGBA_DRV LED driver.
module rgb_led_ctrl import rgb_led_pkg::*; #(
    parameter int PWM_BITS   = 8,
    parameter int PWR_WAIT   = 4800,
    parameter int BLINK_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [1:0]            cfg_mode,
    input  logic [PWM_BITS-1:0]   cfg_red,
    input  logic [PWM_BITS-1:0]   cfg_green,
    input  logic [PWM_BITS-1:0]   cfg_blue,
    input  logic [BLINK_BITS-1:0] cfg_period,
    output logic                  pwm_red,
    output logic                  pwm_green,
    output logic                  pwm_blue,
    output logic                  curr_en,
    output logic                  led_en,
    output logic                  busy
);

    localparam int WAIT_W = $clog2(PWR_WAIT + 1);

    state_e                          state_q, state_d;
    logic                            pend_vld;
    mode_e                           pend_mode, act_mode;
    logic [NUM_CH-1:0][PWM_BITS-1:0] pend_duty, act_duty;
    logic [BLINK_BITS-1:0]           pend_period, act_period;
    logic [WAIT_W-1:0]               wait_q;
    logic                            take, load, frame_end;
    logic [NUM_CH-1:0]               pwm;

    assign cfg_ready = ~pend_vld;
    assign busy      = (state_q != ST_OFF) | pend_vld;

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            ST_OFF: if (pend_vld) begin
                take = 1'b1;
                if (pend_mode != MODE_OFF) begin
                    load    = 1'b1;
                    state_d = ST_WARM;
                end
            end
            ST_WARM: if (wait_q == '0) state_d = ST_RUN;
            // Commands only land on a frame boundary so no PWM pulse is ever cut short.
            ST_RUN: if (frame_end && pend_vld) begin
                take = 1'b1;
                if (pend_mode == MODE_OFF) state_d = ST_SHUTDOWN;
                else                       load    = 1'b1;
            end
            ST_SHUTDOWN: state_d = ST_OFF;
            default:     state_d = ST_OFF;
        endcase
    end

    // Enables are registered from next state so the driver pins never see decode glitches.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_OFF;
            curr_en     <= 1'b0;
            led_en      <= 1'b0;
            pend_vld    <= 1'b0;
            pend_mode   <= MODE_OFF;
            pend_duty   <= '0;
            pend_period <= '0;
            act_mode    <= MODE_OFF;
            act_duty    <= '0;
            act_period  <= '0;
            wait_q      <= '0;
        end else begin
            state_q <= state_d;
            curr_en <= (state_d != ST_OFF);
            led_en  <= (state_d == ST_RUN);
            if (take) begin
                pend_vld <= 1'b0;
            end else if (cfg_valid && !pend_vld) begin
                pend_vld    <= 1'b1;
                pend_mode   <= mode_e'(cfg_mode);
                pend_duty   <= {cfg_blue, cfg_green, cfg_red};
                pend_period <= cfg_period;
            end
            if (load) begin
                act_mode   <= pend_mode;
                act_duty   <= pend_duty;
                act_period <= pend_period;
            end
            if (state_q == ST_OFF)
                wait_q <= WAIT_W'(PWR_WAIT - 1);
            else if (state_q == ST_WARM && wait_q != '0)
                wait_q <= wait_q - WAIT_W'(1);
        end
    end

    rgb_pwm_core #(
        .PWM_BITS   (PWM_BITS),
        .BLINK_BITS (BLINK_BITS)
    ) u_core (
        .clk       (clk),
        .rstn      (rstn),
        .run       (state_q == ST_RUN),
        .restart   (load && state_q == ST_RUN),
        .blink_en  (act_mode == MODE_BLINK),
        .period    (act_period),
        .duty      (act_duty),
        .frame_end (frame_end),
        .pwm       (pwm)
    );

    assign pwm_red   = pwm[0];
    assign pwm_green = pwm[1];
    assign pwm_blue  = pwm[2];

endmodule

// File: tb/tb_rgb_led_ctrl.sv
// Directed bench for rgb_led_ctrl with PWM_BITS=4, PWR_WAIT=4, BLINK_BITS=4.
module tb_rgb_led_ctrl;

    localparam int PB = 4;
    localparam int PW = 4;
    localparam int BB = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_mode = 2'd0;
    logic [PB-1:0] cfg_red = '0, cfg_green = '0, cfg_blue = '0;
    logic [BB-1:0] cfg_period = '0;
    logic          pwm_red, pwm_green, pwm_blue, curr_en, led_en, busy;

    int vecs = 0;
    int errs = 0;

    wire [5:0] outs = {pwm_red, pwm_green, pwm_blue, curr_en, led_en, busy};

    always #5 clk = ~clk;

    rgb_led_ctrl #(.PWM_BITS(PB), .PWR_WAIT(PW), .BLINK_BITS(BB)) dut (
        .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_red(cfg_red), .cfg_green(cfg_green),
        .cfg_blue(cfg_blue), .cfg_period(cfg_period), .pwm_red(pwm_red),
        .pwm_green(pwm_green), .pwm_blue(pwm_blue), .curr_en(curr_en),
        .led_en(led_en), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [1:0] m, input int r, input int g, input int b, input int p);
        cfg_mode   = m;
        cfg_red    = PB'(r);
        cfg_green  = PB'(g);
        cfg_blue   = PB'(b);
        cfg_period = BB'(p);
    endtask

    // One 16-cycle frame starting right after a wrap edge; optionally offers the
    // staged command at step cmd_i.
    task automatic frame(input int cmd_i, output int cr, output int cg, output int cb);
        cr = 0; cg = 0; cb = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == cmd_i) cfg_valid = 1'b1;
            step();
            cfg_valid = 1'b0;
            cr += int'(pwm_red);
            cg += int'(pwm_green);
            cb += int'(pwm_blue);
        end
    endtask

    task automatic power_up(input string tag);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk({tag, "_acc_curr"}, curr_en, 0);
        chk({tag, "_acc_rdy"}, cfg_ready, 0);
        chk({tag, "_acc_busy"}, busy, 1);
        step();
        chk({tag, "_curr_on"}, curr_en, 1);
        chk({tag, "_led_off"}, led_en, 0);
        chk({tag, "_rdy_back"}, cfg_ready, 1);
        step(); step(); step();
        chk({tag, "_led_wait"}, led_en, 0);
        step();
        chk({tag, "_led_on"}, led_en, 1);
        chk({tag, "_pwm_idle"}, {pwm_red, pwm_green, pwm_blue}, 0);
    endtask

    always @(negedge clk) chk("led_wo_curr", 32'(led_en & ~curr_en), 0);

    int r, g, b;
    int blink2 [5] = '{15, 15, 0, 0, 15};
    int blink0 [4] = '{15, 0, 15, 0};

    initial begin
        step(); step();
        chk("rst_outs", outs, 0);
        chk("rst_rdy", cfg_ready, 1);
        rstn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_outs", outs, 0);
            chk("idle_rdy", cfg_ready, 1);
        end

        set_cmd(2'd1, 8, 0, 15, 0);
        power_up("solid");
        frame(-1, r, g, b);
        chk("solid_r", r, 8); chk("solid_g", g, 0); chk("solid_b", b, 15);

        // update offered mid-frame at pwm_ctr=5
        set_cmd(2'd1, 2, 0, 15, 0);
        r = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) cfg_valid = 1'b1;
            step();
            cfg_valid = 1'b0;
            r += int'(pwm_red);
            if (i == 10) chk("mid_rdy_lo", cfg_ready, 0);
            if (i == 15) chk("mid_rdy_hi", cfg_ready, 1);
        end
        chk("mid_old_r", r, 8);
        frame(-1, r, g, b);
        chk("mid_new_r", r, 2); chk("mid_new_b", b, 15);

        set_cmd(2'd2, 15, 0, 0, 2);
        frame(0, r, g, b);
        chk("blink_pre_r", r, 2);
        for (int f = 0; f < 5; f++) begin
            frame(-1, r, g, b);
            chk("blink2_r", r, blink2[f]);
            chk("blink2_b", b, 0);
        end

        set_cmd(2'd2, 15, 0, 0, 0);
        frame(0, r, g, b);
        chk("blink0_pre_r", r, 15);
        for (int f = 0; f < 4; f++) begin
            frame(-1, r, g, b);
            chk("blink0_r", r, blink0[f]);
        end

        set_cmd(2'd0, 0, 0, 0, 0);
        frame(0, r, g, b);
        chk("off_last_r", r, 15);
        chk("off_led", led_en, 0);
        chk("off_curr_hold", curr_en, 1);
        chk("off_pwm", {pwm_red, pwm_green, pwm_blue}, 0);
        step();
        chk("off_curr", curr_en, 0);
        chk("off_busy", busy, 0);
        chk("off_rdy", cfg_ready, 1);

        // reset during WARM
        set_cmd(2'd1, 8, 0, 15, 0);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step(); step();
        chk("warm_curr", curr_en, 1);
        rstn = 1'b0;
        step();
        chk("warm_rst_outs", outs, 0);
        chk("warm_rst_rdy", cfg_ready, 1);
        rstn = 1'b1;
        step();
        power_up("rewarm");
        frame(-1, r, g, b);
        chk("rewarm_r", r, 8); chk("rewarm_b", b, 15);

        // reset during RUN, then restart with reserved mode acting as SOLID
        step(); step(); step();
        rstn = 1'b0;
        step();
        chk("run_rst_outs", outs, 0);
        chk("run_rst_rdy", cfg_ready, 1);
        rstn = 1'b1;
        step();
        set_cmd(2'd3, 8, 0, 15, 1);
        power_up("rsvd");
        frame(-1, r, g, b);
        chk("rsvd_r0", r, 8);
        frame(-1, r, g, b);
        chk("rsvd_r1", r, 8); chk("rsvd_g1", g, 0); chk("rsvd_b1", b, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/rgb_led_ctrl.md
# rgb_led_ctrl

Sequencing and PWM controller for the iCE40 `SB_RGBA_DRV` hard LED driver. It accepts colour/mode commands over a valid/ready handshake and powers the driver up in order: `CURREN` first, then a settle wait, then `RGBLEDEN`. It generates glitch-free per-channel PWM with optional blinking, and powers the driver down in reverse order. It sits between the design's status logic and the `RGB0PWM..RGB2PWM`, `CURREN` and `RGBLEDEN` pins of the driver primitive.

## Interface
- `PWM_BITS`, 8: PWM counter and duty width; frame = 2^PWM_BITS cycles.
- `PWR_WAIT`, 4800: cycles between `curr_en` rising and `led_en` rising (≥1).
- `BLINK_BITS`, 8: width of blink period, in PWM frames.
- `clk` in 1: single clock, same `clk` as the rest of the design.
- `rstn` in 1: reset, synchronous, active-low.
- `cfg_valid` in 1: command valid.
- `cfg_ready` out 1: command slot free.
- `cfg_mode` in 2: 0 OFF, 1 SOLID, 2 BLINK, 3 reserved (treated as SOLID).
- `cfg_red`, `cfg_green`, `cfg_blue` in PWM_BITS each: duty values.
- `cfg_period` in BLINK_BITS: blink half-period in frames; 0 treated as 1.
- `pwm_red`, `pwm_green`, `pwm_blue` out 1: to driver PWM inputs.
- `curr_en` out 1: to `CURREN`.
- `led_en` out 1: to `RGBLEDEN`.
- `busy` out 1: state ≠ OFF or pending command held.

## Operation
- Single pending slot. A command is accepted when `cfg_valid & cfg_ready`. `cfg_ready` is low while the slot is full and goes high the cycle after the slot drains.
- FSM states: OFF, WARM, RUN, SHUTDOWN.
- OFF: all outputs 0. A pending non-OFF command is applied on the next edge: its duties, mode and period load into the active registers, `curr_en` goes to 1, the wait counter loads PWR_WAIT-1, and the FSM enters WARM. A pending OFF command is consumed with no effect.
- WARM: `curr_en`=1, `led_en`=0, PWM outputs 0. The wait counter decrements each cycle; at 0 the FSM enters RUN with `pwm_ctr`=0, `frame_ctr`=0 and blink phase ON. A pending command is held, not applied.
- RUN: `curr_en`=`led_en`=1. `pwm_ctr` free-runs and wraps at 2^PWM_BITS-1 (the frame boundary). A pending command is applied only at a frame boundary, so active registers change on the wrap edge.
  - Applied non-OFF command: restarts blink with phase ON and `frame_ctr`=0.
  - Applied OFF command: FSM enters SHUTDOWN and PWM outputs go to 0.
- SHUTDOWN: `led_en`=0, `curr_en`=1 for exactly one cycle, then OFF. A held pending command is applied from OFF as above.
- PWM: `pwm_x` is registered as RUN & phase & (`pwm_ctr` < duty_x). Duty 0 means never high; duty 2^PWM_BITS-1 means high 255 of 256 cycles.
- Blink (mode BLINK): at each frame boundary, `frame_ctr` increments. When it equals max(period,1)-1, phase toggles and `frame_ctr` clears. In SOLID mode phase is forced ON.

## Timing
- Reset (`rstn`=0 at an edge): state OFF. `cfg_ready`=1, all other outputs 0, all counters and the slot cleared. Reset mid-operation drops `led_en` and `curr_en` on the same edge, with no ordered shutdown.
- From accept in OFF to `curr_en` high: 2 edges (slot load, then apply).
- `curr_en` rising to `led_en` rising: exactly PWR_WAIT cycles.
- PWM output lags its compare by 1 cycle.
- Command accepted in RUN takes effect at the next frame boundary. Worst-case latency is 2^PWM_BITS+1 cycles.
- `led_en` always falls at least 1 cycle before `curr_en`. `curr_en` never falls while `led_en`=1.

## Structure
- Package `rgb_led_pkg`: mode encoding (`MODE_OFF/SOLID/BLINK`), FSM state enum.
- Sub-module `rgb_pwm_core`: `pwm_ctr`, three compares, frame-boundary strobe, blink phase/`frame_ctr`. The top level holds the FSM, handshake slot and wait counter.

## Test plan
All scenarios use PWM_BITS=4, PWR_WAIT=4, BLINK_BITS=4.
- Reset then idle: all outputs 0, `cfg_ready`=1, `busy`=0 for 50 cycles.
- SOLID r=8, g=0, b=15 from OFF:
  - `curr_en` rises 2 cycles after accept; `led_en` rises 4 cycles later.
  - Per 16-cycle frame: `pwm_red` high 8 cycles, `pwm_green` 0, `pwm_blue` 15.
- Mid-frame update r=8 → r=2 accepted at `pwm_ctr`=5: the current frame keeps 8 high; the next frame is 2 high. `cfg_ready` is low until the wrap.
- BLINK r=15, period=2: `pwm_red` active 2 frames, 0 for 2 frames, repeating. Period=0 behaves as period=1.
- OFF command in RUN: at the frame boundary `led_en`→0; `curr_en`→0 one cycle later; `busy`→0.
- `rstn`=0 asserted during WARM and during RUN: all outputs 0 after that edge. After release, a new SOLID command runs the full PWR_WAIT sequence again.
